// File: rtl/ysyx_22050078_if_id_buf.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22050078_if_id_buf
// Brief   : Two-entry IF->ID skid FIFO of {pc, inst} with flush; bubbles when empty.
// Rev     : 1.0
// ============================================================================
module ysyx_22050078_if_id_buf #(
    parameter int                    CPU_WIDTH  = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [CPU_WIDTH-1:0]  i_pc,
    input  logic [INST_WIDTH-1:0] i_inst,
    output logic                  o_ready,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [CPU_WIDTH-1:0]  o_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    input  logic                  i_idu_ready,
    output logic [1:0]            o_count
);

    logic [CPU_WIDTH-1:0]  pc_q   [2];
    logic [INST_WIDTH-1:0] inst_q [2];
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [1:0]            count_q, count_d;
    logic                  w_push, w_pop;

    assign o_ready = rst_n & (count_q != 2'd2);
    assign o_valid = (count_q != 2'd0);
    assign o_count = count_q;
    assign o_pc    = o_valid ? pc_q[rptr_q]   : '0;
    assign o_inst  = o_valid ? inst_q[rptr_q] : NOP_INST;

    assign w_push  = i_valid & o_ready & ~i_flush;
    assign w_pop   = o_valid & i_idu_ready & ~i_flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // Flush wins over any same-cycle push/pop and restarts both pointers.
        if (i_flush) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (w_push) wptr_d = ~wptr_q;
            if (w_pop)  rptr_d = ~rptr_q;
            count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_q[wptr_q]   <= i_pc;
            inst_q[wptr_q] <= i_inst;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050078_if_id_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_22050078_if_id_buf
// Brief   : Directed vector table plus randomized queue-model run for the IF/ID buffer.
// Rev     : 1.0
// ============================================================================
module tb_ysyx_22050078_if_id_buf;

    localparam logic [31:0] C_NOP = 32'h0000_0013;
    localparam logic [63:0] P0 = 64'h8000_0000, P1 = 64'h8000_0004, P2 = 64'h8000_0008;
    localparam logic [63:0] P3 = 64'h8000_0010, P4 = 64'h8000_0020;
    localparam logic [31:0] I0 = 32'h0010_0093, I1 = 32'h0020_0113, I2 = 32'h0030_0193;
    localparam logic [31:0] I3 = 32'h0040_0213, I4 = 32'h0050_0293;

    logic        clk = 1'b0;
    logic        rst_n, i_valid, i_flush, i_idu_ready;
    logic [63:0] i_pc;
    logic [31:0] i_inst;
    logic        o_ready, o_valid;
    logic [63:0] o_pc;
    logic [31:0] o_inst;
    logic [1:0]  o_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_22050078_if_id_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_pc       (i_pc),
        .i_inst     (i_inst),
        .o_ready    (o_ready),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .o_pc       (o_pc),
        .o_inst     (o_inst),
        .i_idu_ready(i_idu_ready),
        .o_count    (o_count)
    );

    typedef struct {
        logic        rst_n, valid;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        flush, rdy;
        logic        ov;
        logic [63:0] opc;
        logic [31:0] oinst;
        logic [1:0]  ocnt;
        logic        ordy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic [63:0] pc, logic [31:0] inst, logic f,
                                logic rd, logic ov, logic [63:0] opc, logic [31:0] oinst,
                                logic [1:0] ocnt, logic ordy);
        vec_t t;
        t.rst_n = r; t.valid = v; t.pc = pc; t.inst = inst; t.flush = f; t.rdy = rd;
        t.ov = ov; t.opc = opc; t.oinst = oinst; t.ocnt = ocnt; t.ordy = ordy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic f, input logic rd);
        rst_n = r; i_valid = v; i_pc = pc; i_inst = inst; i_flush = f; i_idu_ready = rd;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] q_pc[$];
    logic [31:0] q_inst[$];

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_pc = '0; i_inst = '0; i_flush = 1'b0; i_idu_ready = 1'b0;

        // rst, valid, pc, inst, flush, rdy  ->  o_valid, o_pc, o_inst, o_count, o_ready
        vecs.push_back(mk(0, 1, P0, I0, 0, 1,  0, 64'h0, C_NOP, 2'd0, 0)); // in reset
        vecs.push_back(mk(1, 1, P0, I0, 0, 1,  1, P0,    I0,    2'd1, 1)); // 1-cycle latency
        vecs.push_back(mk(1, 0, 64'h0, 32'h0, 0, 1,  0, 64'h0, C_NOP, 2'd0, 1)); // bubble
        vecs.push_back(mk(1, 1, P0, I0, 0, 0,  1, P0,    I0,    2'd1, 1));
        vecs.push_back(mk(1, 1, P1, I1, 0, 0,  1, P0,    I0,    2'd2, 0)); // full
        vecs.push_back(mk(1, 1, P2, I2, 0, 0,  1, P0,    I0,    2'd2, 0)); // push refused
        vecs.push_back(mk(1, 1, P2, I2, 0, 1,  1, P1,    I1,    2'd1, 1)); // pop only
        vecs.push_back(mk(1, 0, 64'h0, 32'h0, 0, 1,  0, 64'h0, C_NOP, 2'd0, 1));
        vecs.push_back(mk(1, 1, P2, I2, 0, 0,  1, P2,    I2,    2'd1, 1));
        vecs.push_back(mk(1, 1, P3, I3, 0, 1,  1, P3,    I3,    2'd1, 1)); // push+pop at 1
        vecs.push_back(mk(1, 1, P1, I1, 0, 0,  1, P3,    I3,    2'd2, 0));
        vecs.push_back(mk(1, 1, P4, I4, 1, 1,  0, 64'h0, C_NOP, 2'd0, 1)); // flush drops P4
        vecs.push_back(mk(1, 0, 64'h0, 32'h0, 0, 1,  0, 64'h0, C_NOP, 2'd0, 1)); // no underflow
        vecs.push_back(mk(1, 1, P0, I0, 0, 0,  1, P0,    I0,    2'd1, 1));
        vecs.push_back(mk(1, 1, P1, I1, 0, 0,  1, P0,    I0,    2'd2, 0));
        vecs.push_back(mk(0, 0, 64'h0, 32'h0, 0, 0,  0, 64'h0, C_NOP, 2'd0, 0)); // mid-op reset
        vecs.push_back(mk(1, 1, P0, I0, 0, 0,  1, P0,    I0,    2'd1, 1));
        vecs.push_back(mk(1, 0, 64'h0, 32'h0, 0, 1,  0, 64'h0, C_NOP, 2'd0, 1));
        vecs.push_back(mk(1, 1, P2, I2, 0, 0,  1, P2,    I2,    2'd1, 1));
        vecs.push_back(mk(1, 0, 64'h0, 32'h0, 1, 1,  0, 64'h0, C_NOP, 2'd0, 1)); // flush beats pop
        vecs.push_back(mk(1, 1, P3, I3, 0, 0,  1, P3,    I3,    2'd1, 1));
        vecs.push_back(mk(1, 1, P4, I4, 0, 1,  1, P4,    I4,    2'd1, 1));
        vecs.push_back(mk(1, 0, 64'h0, 32'h0, 0, 1,  0, 64'h0, C_NOP, 2'd0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].pc, vecs[i].inst, vecs[i].flush, vecs[i].rdy);
            chk($sformatf("v%0d o_valid", i), {63'h0, o_valid}, {63'h0, vecs[i].ov});
            chk($sformatf("v%0d o_pc", i),    o_pc,             vecs[i].opc);
            chk($sformatf("v%0d o_inst", i),  {32'h0, o_inst},  {32'h0, vecs[i].oinst});
            chk($sformatf("v%0d o_count", i), {62'h0, o_count}, {62'h0, vecs[i].ocnt});
            chk($sformatf("v%0d o_ready", i), {63'h0, o_ready}, {63'h0, vecs[i].ordy});
        end

        // Randomized run against a queue model; buffer is empty here.
        begin
            logic [63:0] npc;
            logic [63:0] exp_pc;
            logic [31:0] exp_inst;
            logic        v, f, rd, push, pop;
            npc = 64'h8000_1000;
            i_pc = npc; i_inst = $urandom;
            for (int c = 0; c < 3000; c++) begin
                v  = ($urandom_range(0, 9) < 7);
                f  = ($urandom_range(0, 15) == 0);
                rd = ($urandom_range(0, 9) < 6);
                push = v && (q_pc.size() != 2) && !f;
                pop  = (q_pc.size() != 0) && rd && !f;
                rst_n = 1'b1; i_valid = v; i_flush = f; i_idu_ready = rd;
                @(posedge clk);
                #1;
                if (f) begin
                    q_pc.delete(); q_inst.delete();
                end else begin
                    if (pop) begin
                        void'(q_pc.pop_front()); void'(q_inst.pop_front());
                    end
                    if (push) begin
                        q_pc.push_back(i_pc); q_inst.push_back(i_inst);
                    end
                end
                // Move to a fresh instruction only once the current one was taken or dropped.
                if (push || (v && f)) begin
                    npc = npc + 64'd4;
                    i_pc = npc; i_inst = $urandom;
                end
                exp_pc   = (q_pc.size() != 0) ? q_pc[0]   : 64'h0;
                exp_inst = (q_pc.size() != 0) ? q_inst[0] : C_NOP;
                tests++;
                if (o_valid !== (q_pc.size() != 0) || o_pc !== exp_pc || o_inst !== exp_inst ||
                    o_count !== 2'(q_pc.size()) || o_ready !== (q_pc.size() != 2)) begin
                    fails++;
                    $display("FAIL rand c%0d: got v=%b pc=%h inst=%h cnt=%0d rdy=%b expected v=%b pc=%h inst=%h cnt=%0d rdy=%b",
                             c, o_valid, o_pc, o_inst, o_count, o_ready, (q_pc.size() != 0),
                             exp_pc, exp_inst, q_pc.size(), (q_pc.size() != 2));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
